// File: rtl/ysyx_23060240_csr_pkg.sv
// CSR execution unit shared definitions: CSR addresses, funct3 codes, sequencer states.
// Latency: n/a (constants and a pure decode helper).
// Backpressure: n/a. YSYX_CSR_IMM_EN enables the immediate forms (funct3 101/110/111).
package ysyx_23060240_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } csr_state_t;

    // True when funct3 names a Zicsr operation this build executes.
    function automatic logic f3_is_zicsr(input logic [2:0] f3);
`ifdef YSYX_CSR_IMM_EN
        return f3[1:0] != 2'b00;
`else
        return (f3[2] == 1'b0) && (f3[1:0] != 2'b00);
`endif
    endfunction

endpackage

// File: rtl/ysyx_23060240_csr_alu.sv
// Read-modify-write value for Zicsr ops plus the "write required" decision.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module ysyx_23060240_csr_alu #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    input  logic [4:0]      rs1_idx,
    output logic [XLEN-1:0] new_val,
    output logic            wr_req
);

    logic [XLEN-1:0] opnd;

    // Immediate forms use the zero-extended rs1 field; set/clear with x0/zimm=0 never write.
    always_comb begin
        opnd    = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : src;
        new_val = old;
        wr_req  = 1'b0;
        case (funct3[1:0])
            2'b01: begin
                new_val = opnd;
                wr_req  = 1'b1;
            end
            2'b10: begin
                new_val = old | opnd;
                wr_req  = (rs1_idx != 5'd0);
            end
            2'b11: begin
                new_val = old & ~opnd;
                wr_req  = (rs1_idx != 5'd0);
            end
            default: begin
                new_val = old;
                wr_req  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060240_csr_exu.sv
// Sequences one Zicsr/ecall/mret through CSR-file read, optional write, then a result to writeback.
// Latency: accept -> out_valid in 2 cycles (no write) or 3 cycles (write); one instruction in flight.
// Backpressure: RESP holds all outputs until out_ready; in_ready only in IDLE. YSYX_CSR_IMM_EN adds CSRR*I.
module ysyx_23060240_csr_exu
    import ysyx_23060240_csr_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic [4:0]        rs1_idx,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic              is_ecall,
    input  logic              is_mret,
    input  logic [XLEN-1:0]   pc,
    output logic [ADDR_W-1:0] csr_raddr,
    output logic              csr_ren,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic [ADDR_W-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              csr_wen,
    output logic              csr_finish,
    output logic              trap_ecall,
    output logic              trap_mret,
    output logic [XLEN-1:0]   trap_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   rd_data,
    output logic              rd_wen,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              illegal
);

    csr_state_t        state, state_d;

    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        idx_q;
    logic [XLEN-1:0]   data_q;
    logic              ecall_q;
    logic              mret_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   new_q;
    logic [XLEN-1:0]   rd_data_q;
    logic              rd_wen_q;
    logic              redir_vld_q;
    logic [XLEN-1:0]   redir_pc_q;
    logic              illegal_q;

    logic              op_mret;
    logic              op_zicsr;
    logic [XLEN-1:0]   alu_new;
    logic              alu_wr;

    // ecall wins when both trap flags are set; funct3 only matters without a trap.
    assign op_mret  = mret_q & ~ecall_q;
    assign op_zicsr = ~ecall_q & ~mret_q & f3_is_zicsr(f3_q);

    ysyx_23060240_csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3  (f3_q),
        .old     (csr_rdata),
        .src     (data_q),
        .rs1_idx (idx_q),
        .new_val (alu_new),
        .wr_req  (alu_wr)
    );

    // Next state and CSR-side strobes; strobes are killed while rst is high so a reset
    // landing mid-instruction can never commit anything to the CSR file.
    always_comb begin
        state_d    = state;
        in_ready   = 1'b0;
        csr_ren    = 1'b0;
        trap_ecall = 1'b0;
        trap_mret  = 1'b0;
        csr_wen    = 1'b0;
        csr_finish = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_READ;
            end
            S_READ: begin
                trap_ecall = ecall_q;
                trap_mret  = op_mret;
                csr_ren    = op_zicsr;
                state_d    = (op_zicsr && alu_wr) ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                csr_wen    = 1'b1;
                csr_finish = 1'b1;
                state_d    = S_RESP;
            end
            S_RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            csr_ren    = 1'b0;
            trap_ecall = 1'b0;
            trap_mret  = 1'b0;
            csr_wen    = 1'b0;
            csr_finish = 1'b0;
        end
    end

    // State register, instruction latch on accept, and result capture in READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            f3_q        <= '0;
            addr_q      <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            ecall_q     <= 1'b0;
            mret_q      <= 1'b0;
            pc_q        <= '0;
            new_q       <= '0;
            rd_data_q   <= '0;
            rd_wen_q    <= 1'b0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state <= state_d;
            if (state == S_IDLE && in_valid) begin
                f3_q    <= funct3;
                addr_q  <= csr_addr;
                idx_q   <= rs1_idx;
                data_q  <= rs1_data;
                ecall_q <= is_ecall;
                mret_q  <= is_mret;
                pc_q    <= pc;
            end
            if (state == S_READ) begin
                new_q       <= alu_new;
                rd_data_q   <= op_zicsr ? csr_rdata : '0;
                rd_wen_q    <= op_zicsr;
                redir_vld_q <= ecall_q | mret_q;
                redir_pc_q  <= (ecall_q | mret_q) ? csr_rdata : '0;
                illegal_q   <= ~(ecall_q | mret_q | op_zicsr);
            end
        end
    end

    assign csr_raddr      = csr_ren ? addr_q : '0;
    assign csr_waddr      = csr_wen ? addr_q : '0;
    assign csr_wdata      = csr_wen ? new_q : '0;
    assign trap_pc        = pc_q;
    assign rd_data        = rd_data_q;
    assign rd_wen         = out_valid & rd_wen_q;
    assign redirect_valid = out_valid & redir_vld_q;
    assign redirect_pc    = redir_pc_q;
    assign illegal        = out_valid & illegal_q;

endmodule

// File: tb/tb_ysyx_23060240_csr_exu.sv
// Randomized bench for the CSR execution unit against a behavioural CSR/ISA reference model.
// Latency: checks 2/3-cycle accept-to-result and single-cycle strobes.
// Backpressure: exercises out_ready stalls and reset in the middle of a write.
module tb_ysyx_23060240_csr_exu;
    import ysyx_23060240_csr_pkg::*;

`ifdef YSYX_CSR_IMM_EN
    localparam bit IMM = 1'b1;
`else
    localparam bit IMM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic        is_ecall, is_mret;
    logic [31:0] pc;
    logic [11:0] csr_raddr, csr_waddr;
    logic        csr_ren, csr_wen, csr_finish;
    logic [31:0] csr_rdata, csr_wdata;
    logic        trap_ecall, trap_mret;
    logic [31:0] trap_pc;
    logic        out_valid, out_ready;
    logic [31:0] rd_data;
    logic        rd_wen, redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal;

    always #5 clk = ~clk;

    ysyx_23060240_csr_exu #(.XLEN(32), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_data(rs1_data),
        .is_ecall(is_ecall), .is_mret(is_mret), .pc(pc),
        .csr_raddr(csr_raddr), .csr_ren(csr_ren), .csr_rdata(csr_rdata),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen), .csr_finish(csr_finish),
        .trap_ecall(trap_ecall), .trap_mret(trap_mret), .trap_pc(trap_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd_data(rd_data), .rd_wen(rd_wen),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .illegal(illegal)
    );

    // CSR file environment (driven by DUT strobes) and the independent reference contents.
    logic [31:0] csr_mem [0:4095];
    logic [31:0] ref_csr [0:4095];

    always_comb begin
        if (trap_ecall)     csr_rdata = csr_mem[CSR_MTVEC];
        else if (trap_mret) csr_rdata = csr_mem[CSR_MEPC];
        else if (csr_ren)   csr_rdata = csr_mem[csr_raddr];
        else                csr_rdata = 32'd0;
    end

    int          wen_cnt = 0, ecall_cnt = 0, mret_cnt = 0, strobe_viol = 0;
    logic [31:0] last_wdata = '0;
    logic [11:0] last_waddr = '0;

    // CSR file behaviour plus strobe sanity, sampled mid-cycle.
    always @(negedge clk) begin
        if (csr_wen && csr_finish) begin
            csr_mem[csr_waddr] <= csr_wdata;
            wen_cnt    <= wen_cnt + 1;
            last_wdata <= csr_wdata;
            last_waddr <= csr_waddr;
        end
        if (trap_ecall) begin
            csr_mem[CSR_MEPC]   <= trap_pc;
            csr_mem[CSR_MCAUSE] <= 32'd11;
            ecall_cnt <= ecall_cnt + 1;
        end
        if (trap_mret) mret_cnt <= mret_cnt + 1;
        if ((csr_wen | csr_finish | csr_ren | trap_ecall | trap_mret) && (in_ready | out_valid))
            strobe_viol <= strobe_viol + 1;
        else if (csr_wen != csr_finish)
            strobe_viol <= strobe_viol + 1;
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                         input logic [31:0] data, input logic ec, input logic mr,
                         input logic [31:0] ipc, input int hold);
        logic        tr_e, tr_m, legal_z, wr;
        logic [31:0] old, src, nv, exp_redir;
        logic [31:0] s_rd, s_rp;
        logic        s_rw, s_rv, s_il;
        int          exp_lat, cyc, w0, e0, m0;
        // Architectural expectation from the ISA rules.
        tr_e    = ec;
        tr_m    = mr && !ec;
        legal_z = !ec && !mr && ((f3 >= 3'd1 && f3 <= 3'd3) || (IMM && f3 >= 3'd5));
        old     = ref_csr[addr];
        src     = (f3 >= 3'd5) ? {27'd0, idx} : data;
        if (f3 == 3'd1 || f3 == 3'd5)      nv = src;
        else if (f3 == 3'd2 || f3 == 3'd6) nv = old | src;
        else                               nv = old & ~src;
        wr        = legal_z && (f3 == 3'd1 || f3 == 3'd5 || idx != 5'd0);
        exp_lat   = wr ? 3 : 2;
        exp_redir = tr_e ? ref_csr[CSR_MTVEC] : (tr_m ? ref_csr[CSR_MEPC] : 32'd0);
        w0 = wen_cnt; e0 = ecall_cnt; m0 = mret_cnt;

        @(negedge clk);
        funct3 = f3; csr_addr = addr; rs1_idx = idx; rs1_data = data;
        is_ecall = ec; is_mret = mr; pc = ipc; in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        funct3 = $urandom; rs1_data = $urandom; pc = $urandom;
        cyc = 1;
        while (!out_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("rd_wen", 32'(rd_wen), 32'(legal_z));
        check("redirect_valid", 32'(redirect_valid), 32'(tr_e | tr_m));
        check("illegal", 32'(illegal), 32'(!legal_z && !tr_e && !tr_m));
        if (legal_z) check("rd_data", rd_data, old);
        if (tr_e || tr_m) check("redirect_pc", redirect_pc, exp_redir);
        s_rd = rd_data; s_rp = redirect_pc; s_rw = rd_wen; s_rv = redirect_valid; s_il = illegal;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_outputs", {s_rw, s_rv, s_il, rd_data ^ s_rd ^ redirect_pc ^ s_rp},
                  {rd_wen, redirect_valid, illegal, 29'd0, 3'd0} ^ {3'd0, 29'd0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("released_valid", 32'(out_valid), 32'd0);
        check("released_in_ready", 32'(in_ready), 32'd1);
        check("wen_pulses", 32'(wen_cnt - w0), 32'(wr));
        if (wr) begin
            check("wdata", last_wdata, nv);
            check("waddr", 32'(last_waddr), 32'(addr));
        end
        check("ecall_pulses", 32'(ecall_cnt - e0), 32'(tr_e));
        check("mret_pulses", 32'(mret_cnt - m0), 32'(tr_m));
        if (wr) ref_csr[addr] = nv;
        if (tr_e) begin
            ref_csr[CSR_MEPC]   = ipc;
            ref_csr[CSR_MCAUSE] = 32'd11;
        end
        check("csr_contents", csr_mem[addr], ref_csr[addr]);
        check("mepc_contents", csr_mem[CSR_MEPC], ref_csr[CSR_MEPC]);
    endtask

    logic [11:0] addr_tab [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_tab[0] = CSR_MSTATUS; addr_tab[1] = CSR_MTVEC;
        addr_tab[2] = CSR_MEPC;    addr_tab[3] = CSR_MCAUSE;
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i] = 32'd0;
            ref_csr[i] = 32'd0;
        end
        csr_mem[CSR_MSTATUS] = 32'h1800;     ref_csr[CSR_MSTATUS] = 32'h1800;
        csr_mem[CSR_MTVEC]   = 32'h80000200; ref_csr[CSR_MTVEC]   = 32'h80000200;
        csr_mem[CSR_MEPC]    = 32'hFF;       ref_csr[CSR_MEPC]    = 32'hFF;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        funct3 = '0; csr_addr = '0; rs1_idx = '0; rs1_data = '0;
        is_ecall = 1'b0; is_mret = 1'b0; pc = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_strobes", {27'd0, csr_ren, csr_wen, csr_finish, trap_ecall, trap_mret}, 32'd0);
        check("rst_flags", {28'd0, out_valid, rd_wen, redirect_valid, illegal}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_trap_pc", trap_pc, 32'd0);
        check("rst_addrs", {8'd0, csr_raddr, csr_waddr}, 32'd0);
        check("rst_wdata", csr_wdata, 32'd0);

        // Directed scenarios.
        issue(F3_CSRRW, CSR_MTVEC,   5'd1, 32'h80000100, 1'b0, 1'b0, 32'h0, 0);
        issue(F3_CSRRW, CSR_MTVEC,   5'd1, 32'h80000200, 1'b0, 1'b0, 32'h0, 1);
        issue(F3_CSRRS, CSR_MSTATUS, 5'd0, 32'h00001234, 1'b0, 1'b0, 32'h0, 0);
        issue(F3_CSRRC, CSR_MEPC,    5'd2, 32'h0000000F, 1'b0, 1'b0, 32'h0, 5);
        issue(F3_PRIV,  12'h000,     5'd0, 32'h0,        1'b1, 1'b0, 32'h80000040, 0);
        issue(F3_CSRRS, CSR_MEPC,    5'd0, 32'h0,        1'b0, 1'b0, 32'h0, 0);
        issue(F3_PRIV,  12'h302,     5'd0, 32'h0,        1'b0, 1'b1, 32'h0, 2);
        issue(3'b100,   CSR_MSTATUS, 5'd3, 32'hFFFF,     1'b0, 1'b0, 32'h0, 0);
        issue(F3_CSRRWI, CSR_MCAUSE, 5'd7, 32'h0,        1'b0, 1'b0, 32'h0, 0);
        issue(F3_CSRRSI, CSR_MSTATUS, 5'd8, 32'h0,       1'b0, 1'b0, 32'h0, 0);
        issue(F3_CSRRCI, CSR_MSTATUS, 5'd0, 32'h0,       1'b0, 1'b0, 32'h0, 0);
        issue(F3_CSRRW, CSR_MTVEC,   5'd0, 32'h80000300, 1'b1, 1'b1, 32'h80000080, 0);

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            logic [4:0] idx;
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            issue(3'($urandom), addr_tab[$urandom_range(0, 3)], idx, $urandom,
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                  $urandom, $urandom_range(0, 3));
        end

        // Reset landing in WRITE must abort without a write strobe.
        @(negedge clk);
        funct3 = F3_CSRRW; csr_addr = CSR_MCAUSE; rs1_idx = 5'd1; rs1_data = 32'hDEADBEEF;
        is_ecall = 1'b0; is_mret = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("write_state_wen", 32'(csr_wen), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_write_wen", {30'd0, csr_wen, csr_finish}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_strobes", {27'd0, csr_ren, csr_wen, csr_finish, trap_ecall, trap_mret}, 32'd0);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("rst_no_commit", csr_mem[CSR_MCAUSE], ref_csr[CSR_MCAUSE]);
        check("strobe_violations", 32'(strobe_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060240_csr_exu.md
# ysyx_23060240_csr_exu

CSR execution unit sitting directly upstream of the CSR register file in the NPC core. It accepts one decoded Zicsr/ecall/mret instruction at a time from the decode stage and sequences the CSR-file read, the read-modify-write value and the `finish`-qualified write strobe. It then returns the old CSR value for rd, or a PC redirect for traps, to writeback through a valid/ready handshake. It never holds more than one instruction in flight.

## Interface
Parameters:
- XLEN, 32, data width
- ADDR_W, 12, CSR address width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  unit can accept (IDLE only)
- funct3  in  3  Zicsr funct3
- csr_addr  in  12  CSR address field
- rs1_idx  in  5  rs1 field / zimm
- rs1_data  in  32  rs1 register value
- is_ecall  in  1  instruction is ecall
- is_mret  in  1  instruction is mret
- pc  in  32  instruction PC
- csr_raddr  out  12  to CSR file read address
- csr_ren  out  1  to CSR file read enable
- csr_rdata  in  32  from CSR file read data (combinational)
- csr_waddr  out  12  to CSR file write address
- csr_wdata  out  32  to CSR file write data
- csr_wen  out  1  to CSR file write enable
- csr_finish  out  1  to CSR file commit qualifier
- trap_ecall  out  1  to CSR file jump_ecall
- trap_mret  out  1  to CSR file jump_mret
- trap_pc  out  32  to CSR file pc (latched instruction PC)
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts
- rd_data  out  32  old CSR value
- rd_wen  out  1  rd write required
- redirect_valid  out  1  next PC is redirect_pc
- redirect_pc  out  32  mtvec (ecall) or mepc (mret)
- illegal  out  1  unsupported funct3

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: in_ready=1. On in_valid, latch all inputs and go to READ.
- READ, ecall (priority if is_ecall and is_mret are both set): trap_ecall=1, csr_ren=0. Capture csr_rdata (mtvec) into redirect_pc. The CSR file writes mepc=trap_pc on this edge. Go to RESP.
- READ, mret: trap_mret=1, csr_ren=0. Capture mepc into redirect_pc. Go to RESP.
- READ, Zicsr: csr_ren=1, csr_raddr=addr. Capture csr_rdata as old, compute new. Go to WRITE if a write is required, else RESP.
- New-value rules: src = rs1_data for 001/010/011; src = zero-extended rs1_idx for 101/110/111.
  - RW: new=src
  - RS: new=old|src
  - RC: new=old&~src
- Write suppression: RS/RC (and RSI/RCI) with rs1_idx==0 do not write. RW/RWI always write.
- WRITE: csr_wen=1 and csr_finish=1 for exactly one cycle, with csr_waddr=addr and csr_wdata=new. Then go to RESP.
- Illegal: funct3 000/100 without ecall/mret → no CSR access. RESP with illegal=1, rd_wen=0.
- RESP: out_valid=1. Stay until out_ready; then return to IDLE. rd_wen=1 for legal Zicsr, 0 for traps and illegal. redirect_valid=1 for traps only.

## Timing
- Latency from accept to out_valid: 2 cycles without a write, 3 with a write.
- Minimum issue interval is 3 or 4 cycles.
- All CSR-side strobes are single-cycle pulses and are never asserted in IDLE or RESP.
- Reset values: state=IDLE, in_ready=1. All other outputs, strobes and data are 0.
- Reset in any state aborts the instruction with no CSR strobe on the reset cycle.
- Outputs hold stable while out_valid=1 and out_ready=0.

## Configuration
- YSYX_CSR_IMM_EN defined: funct3 101/110/111 are executed as CSRRWI/CSRRSI/CSRRCI.
- YSYX_CSR_IMM_EN undefined: funct3 101/110/111 are illegal (illegal=1, no CSR access).

## Structure
- Package ysyx_23060240_csr_pkg holds:
  - CSR address constants: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342
  - funct3 codes
  - state enum
- Sub-module ysyx_23060240_csr_alu: combinational; takes funct3, old, src, rs1_idx; produces new value and write-required flag.

## Test plan
- CSRRW 0x305, rs1_data=0x80000100 → one WRITE pulse with wdata=0x80000100; rd_data equals prior mtvec; out_valid on cycle 3.
- CSRRS 0x300, rs1_idx=0 → csr_wen never asserted; rd_data=0x1800; out_valid on cycle 2.
- CSRRC 0x341 with old=0xFF, rs1_data=0x0F → wdata=0xF0.
- ecall at pc=0x80000040 with mtvec=0x80000200 → trap_ecall one cycle; redirect_pc=0x80000200; later mepc reads 0x80000040.
- mret after the ecall above → redirect_pc=0x80000040; rd_wen=0.
- out_ready held low for 5 cycles → outputs stable and in_ready=0; rst asserted in WRITE → next cycle IDLE with all strobes 0.
